// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, the
// controller state type and the access legality rule.
package load_store_unit_pkg;

    localparam logic [2:0] SIZE_B  = 3'b000;
    localparam logic [2:0] SIZE_H  = 3'b001;
    localparam logic [2:0] SIZE_W  = 3'b010;
    localparam logic [2:0] SIZE_BU = 3'b100;
    localparam logic [2:0] SIZE_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // An access is legal when the size code exists for this direction and the
    // address is naturally aligned for that size.
    function automatic logic access_legal(input logic [2:0] size,
                                          input logic [1:0] lo,
                                          input logic       is_store);
        logic ok;
        case (size)
            SIZE_B:  ok = 1'b1;
            SIZE_H:  ok = ~lo[0];
            SIZE_W:  ok = (lo == 2'b00);
            SIZE_BU: ok = ~is_store;
            SIZE_HU: ok = ~is_store & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Byte-lane steering: store byte enables and data replication on the request
// side, lane extraction and sign/zero extension on the response side.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;

    assign ld_shifted = ld_word >> {ld_lo, 3'b000};

    // Store lanes: sub-word data is replicated so every lane carries it and
    // the byte enables pick which lanes the memory actually writes.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_size)
            SIZE_B: begin
                st_be    = 4'b0001 << st_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SIZE_H: begin
                st_be    = 4'b0011 << st_lo;
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lanes: the addressed lane is shifted down to bit 0, then extended.
    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            SIZE_B:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_H:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
            SIZE_BU: ld_data = {24'h0, ld_shifted[7:0]};
            SIZE_HU: ld_data = {16'h0, ld_shifted[15:0]};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory instruction from execute, runs a single
// request/ack bus transaction and returns the aligned load result.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int AW = 32
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic          st_en,
    input  logic [2:0]    size,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          stall,
    output logic          fault,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack
);

    state_e      state_q, state_d;
    logic        store_q;
    logic [2:0]  size_q;
    logic [1:0]  lo_q;
    logic        req_legal;
    logic        capture;
    logic        stall_raw;
    logic        fault_raw;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] load_value;

    // A simultaneous load and store is handled as a store.
    assign req_legal = access_legal(size, addr[1:0], st_en);

    load_align u_align (
        .st_size  (size),
        .st_lo    (addr[1:0]),
        .st_data  (wdata),
        .st_be    (align_be),
        .st_wdata (align_wdata),
        .ld_size  (size_q),
        .ld_lo    (lo_q),
        .ld_word  (mem_rdata),
        .ld_data  (load_value)
    );

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next state and bus/handshake outputs; enables are only looked at in IDLE.
    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        fault_raw = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_en | st_en) begin
                    if (req_legal) begin
                        stall_raw = 1'b1;
                        capture   = 1'b1;
                        state_d   = ST_BUSY;
                    end else begin
                        fault_raw = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                stall_raw = 1'b1;
                mem_req   = 1'b1;
                mem_we    = store_q;
                if (mem_ack) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset must silence the pipeline handshakes immediately, even while the
    // datapath still presents an enable.
    assign stall = stall_raw & ~rst;
    assign fault = fault_raw & ~rst;

    // Latch the accepted request so the bus sees stable values until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q   <= 1'b0;
            size_q    <= 3'b000;
            lo_q      <= 2'b00;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else if (capture) begin
            store_q   <= st_en;
            size_q    <= size;
            lo_q      <= addr[1:0];
            mem_addr  <= {addr[AW-1:2], 2'b00};
            mem_be    <= st_en ? align_be : 4'b1111;
            mem_wdata <= st_en ? align_wdata : 32'h0;
        end
    end

    // Load result register, written only by an ack that completes a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         rdata <= 32'h0;
        else if (state_q == ST_BUSY && mem_ack && !store_q) rdata <= load_value;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against a reference model written from the access rules.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst, ld_en, st_en, mem_ack;
    logic [2:0]  size;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic        stall, fault, mem_req, mem_we;
    logic [3:0]  mem_be;

    int total  = 0;
    int passed = 0;
    logic [31:0] model_rdata = 32'h0;

    int          obs_stall, obs_fault, obs_busy;
    logic        obs_req_idle, obs_req_done, obs_stall_done, obs_stable, obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_rdata, obs_rdata_after;
    logic [3:0]  obs_be;

    load_store_unit #(.AW(32)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .st_en(st_en), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Reference rules, written directly from the size/alignment table.
    function automatic logic ref_legal(input logic [2:0] sz, input logic [31:0] a, input logic st);
        int lo = int'(a % 4);
        case (sz)
            3'd0: return 1'b1;
            3'd1: return (lo % 2) == 0;
            3'd2: return lo == 0;
            3'd4: return !st;
            3'd5: return !st && (lo % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * (a % 4))) & 32'hFF;
        h = (word >> (8 * (a % 4))) & 32'hFFFF;
        case (sz)
            3'd0: return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1: return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4: return b;
            3'd5: return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic st, input logic [2:0] sz, input logic [31:0] a);
        if (!st) return 4'hF;
        case (sz)
            3'd0: return 4'(1 << (a % 4));
            3'd1: return 4'(3 << (a % 4));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] sz, input logic [31:0] wd);
        case (sz)
            3'd0: return (wd & 32'hFF) * 32'h01010101;
            3'd1: return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    // Drives one instruction through the unit and records what the bus and
    // handshake outputs did; the calling test decides what was expected.
    task automatic run_access(input logic l, input logic s, input logic [2:0] sz,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int wait_n, input logic stray_ack, input logic hold_done);
        logic acked;
        obs_stall = 0; obs_fault = 0; obs_busy = 0; obs_stable = 1'b1;
        obs_req_done = 1'b0; obs_stall_done = 1'b0;
        obs_addr = 32'h0; obs_be = 4'h0; obs_wdata = 32'h0; obs_we = 1'b0;
        ld_en = l; st_en = s; size = sz; addr = a; wdata = wd; mem_rdata = rd; mem_ack = stray_ack;
        @(negedge clk);
        obs_stall = stall ? 1 : 0; obs_fault = fault ? 1 : 0; obs_req_idle = mem_req;
        if (!stall) begin
            @(posedge clk); #1;
            ld_en = 1'b0; st_en = 1'b0; mem_ack = 1'b0;
            @(negedge clk);
            if (fault) obs_fault++;
            obs_req_idle = obs_req_idle | mem_req;
            obs_rdata = rdata; obs_rdata_after = rdata;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        acked = 1'b0;
        for (int k = 0; k < 64 && !acked; k++) begin
            mem_ack = (k == wait_n);
            @(negedge clk);
            if (stall) obs_stall++;
            if (fault) obs_fault++;
            if (k == 0) begin
                obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
                if (mem_req !== 1'b1) obs_stable = 1'b0;
            end else if (mem_req !== 1'b1 || mem_addr !== obs_addr || mem_be !== obs_be ||
                         mem_wdata !== obs_wdata || mem_we !== obs_we) begin
                obs_stable = 1'b0;
            end
            obs_busy++;
            acked = mem_ack;
            @(posedge clk); #1;
        end
        mem_ack = stray_ack; mem_rdata = ~rd;
        if (!hold_done) begin ld_en = 1'b0; st_en = 1'b0; end
        @(negedge clk);
        obs_stall_done = stall; obs_req_done = mem_req; obs_rdata = rdata;
        if (fault) obs_fault++;
        @(posedge clk); #1;
        mem_ack = 1'b0; ld_en = 1'b0; st_en = 1'b0;
        @(negedge clk);
        obs_rdata_after = rdata;
        @(posedge clk); #1;
    endtask

    // Outputs must be zero while reset is held, even with a load presented.
    task automatic test_reset();
        rst = 1'b1; ld_en = 1'b1; st_en = 1'b0; size = 3'd2; addr = 32'h10;
        wdata = 32'hFFFFFFFF; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %b expected 0", stall); else passed++;
        total++; if (fault !== 1'b0) $display("[TB] FAIL reset_fault: got %b expected 0", fault); else passed++;
        total++; if ({mem_req, mem_we, mem_be} !== 6'h0) $display("[TB] FAIL reset_req_we_be: got %h expected 0", {mem_req, mem_we, mem_be}); else passed++;
        total++; if ({mem_addr, mem_wdata, rdata} !== 96'h0) $display("[TB] FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, rdata}); else passed++;
        ld_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rdata = 32'h0;
    endtask

    // Aligned word load with immediate ack.
    task automatic test_lw();
        run_access(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0, 1'b0);
        model_rdata = 32'hDEADBEEF;
        total++; if (obs_stall !== 2) $display("[TB] FAIL lw_stall_cycles: got %0d expected 2", obs_stall); else passed++;
        total++; if (obs_be !== 4'hF) $display("[TB] FAIL lw_be: got %b expected 1111", obs_be); else passed++;
        total++; if (obs_addr !== 32'h10 || obs_we !== 1'b0) $display("[TB] FAIL lw_addr_we: got %h/%b expected 00000010/0", obs_addr, obs_we); else passed++;
        total++; if (obs_rdata !== 32'hDEADBEEF) $display("[TB] FAIL lw_rdata: got %h expected deadbeef", obs_rdata); else passed++;
        total++; if (obs_stall_done !== 1'b0 || obs_req_done !== 1'b0) $display("[TB] FAIL lw_done_stall_req: got %b%b expected 00", obs_stall_done, obs_req_done); else passed++;
        total++; if (obs_fault !== 0 || obs_stable !== 1'b1) $display("[TB] FAIL lw_fault_stable: got %0d/%b expected 0/1", obs_fault, obs_stable); else passed++;
    endtask

    // Signed and unsigned byte loads from the top lane.
    task automatic test_lb();
        run_access(1'b1, 1'b0, 3'd0, 32'h13, 32'h0, 32'h80FF0000, 0, 1'b0, 1'b0);
        total++; if (obs_rdata !== 32'hFFFFFF80) $display("[TB] FAIL lb_rdata: got %h expected ffffff80", obs_rdata); else passed++;
        run_access(1'b1, 1'b0, 3'd4, 32'h13, 32'h0, 32'h80FF0000, 0, 1'b0, 1'b0);
        total++; if (obs_rdata !== 32'h00000080) $display("[TB] FAIL lbu_rdata: got %h expected 00000080", obs_rdata); else passed++;
        model_rdata = 32'h00000080;
    endtask

    // Halfword store into the upper half of a word.
    task automatic test_sh();
        run_access(1'b0, 1'b1, 3'd1, 32'h22, 32'h12345678, 32'hA5A5A5A5, 0, 1'b0, 1'b0);
        total++; if (obs_we !== 1'b1) $display("[TB] FAIL sh_we: got %b expected 1", obs_we); else passed++;
        total++; if (obs_be !== 4'b1100) $display("[TB] FAIL sh_be: got %b expected 1100", obs_be); else passed++;
        total++; if (obs_wdata !== 32'h56785678) $display("[TB] FAIL sh_wdata: got %h expected 56785678", obs_wdata); else passed++;
        total++; if (obs_addr !== 32'h20) $display("[TB] FAIL sh_addr: got %h expected 00000020", obs_addr); else passed++;
        total++; if (obs_rdata_after !== model_rdata) $display("[TB] FAIL sh_rdata_kept: got %h expected %h", obs_rdata_after, model_rdata); else passed++;
    endtask

    // Misaligned word load and illegal size codes fault without a bus request.
    task automatic test_fault();
        logic [2:0] sizes [3];
        logic       stores[3];
        logic [31:0] addrs[3];
        sizes = '{3'd2, 3'd4, 3'd3}; stores = '{1'b0, 1'b1, 1'b0}; addrs = '{32'h11, 32'h40, 32'h40};
        for (int i = 0; i < 3; i++) begin
            run_access(!stores[i], stores[i], sizes[i], addrs[i], 32'h1, 32'h12345678, 0, 1'b0, 1'b0);
            total++; if (obs_fault !== 1) $display("[TB] FAIL fault_pulse_%0d: got %0d cycles expected 1", i, obs_fault); else passed++;
            total++; if (obs_req_idle !== 1'b0 || obs_stall !== 0) $display("[TB] FAIL fault_req_stall_%0d: got %b/%0d expected 0/0", i, obs_req_idle, obs_stall); else passed++;
            total++; if (obs_rdata !== model_rdata) $display("[TB] FAIL fault_rdata_%0d: got %h expected %h", i, obs_rdata, model_rdata); else passed++;
        end
    endtask

    // Word store acknowledged in the fourth busy cycle.
    task automatic test_delayed_store();
        run_access(1'b0, 1'b1, 3'd2, 32'h40, 32'hCAFE1234, 32'h0, 3, 1'b0, 1'b0);
        total++; if (obs_stall !== 5) $display("[TB] FAIL sw_wait_stall: got %0d expected 5", obs_stall); else passed++;
        total++; if (obs_stable !== 1'b1) $display("[TB] FAIL sw_wait_stable: got %b expected 1", obs_stable); else passed++;
        total++; if (obs_req_done !== 1'b0) $display("[TB] FAIL sw_wait_req_drop: got %b expected 0", obs_req_done); else passed++;
        total++; if (obs_wdata !== 32'hCAFE1234 || obs_be !== 4'hF) $display("[TB] FAIL sw_wait_data: got %h/%b expected cafe1234/1111", obs_wdata, obs_be); else passed++;
    endtask

    // Enables held into DONE are not taken; a stray ack in DONE changes nothing.
    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 3'd5, 32'h52, 32'h0, 32'h9ABC0000, 1, 1'b1, 1'b1);
        model_rdata = 32'h00009ABC;
        total++; if (obs_stall_done !== 1'b0 || obs_req_done !== 1'b0) $display("[TB] FAIL b2b_done_resample: got %b%b expected 00", obs_stall_done, obs_req_done); else passed++;
        total++; if (obs_rdata_after !== model_rdata) $display("[TB] FAIL b2b_stray_ack: got %h expected %h", obs_rdata_after, model_rdata); else passed++;
        run_access(1'b1, 1'b0, 3'd1, 32'h52, 32'h0, 32'h9ABC0000, 0, 1'b0, 1'b0);
        model_rdata = 32'hFFFF9ABC;
        total++; if (obs_stall !== 2 || obs_rdata !== model_rdata) $display("[TB] FAIL b2b_second: got %0d/%h expected 2/%h", obs_stall, obs_rdata, model_rdata); else passed++;
    endtask

    // Randomized mix of loads, stores, illegal codes and wait states.
    task automatic test_random();
        logic [2:0]  sz;
        logic [31:0] a, wd, rd;
        logic        l, s, st;
        int          sel, wn;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            l = sel[0]; s = sel[1]; st = s;
            sz = 3'($urandom_range(0, 7));
            a = $urandom & 32'h0000FFFF;
            wd = $urandom; rd = $urandom;
            wn = $urandom_range(0, 3);
            run_access(l, s, sz, a, wd, rd, wn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (ref_legal(sz, a, st)) begin
                if (!st) model_rdata = ref_load(sz, a, rd);
                total++; if (obs_fault !== 0 || obs_stall !== 2 + wn) $display("[TB] FAIL rnd_%0d_fault_stall: got %0d/%0d expected 0/%0d", i, obs_fault, obs_stall, 2 + wn); else passed++;
                total++; if (obs_addr !== (a & 32'hFFFFFFFC) || obs_we !== st || obs_stable !== 1'b1) $display("[TB] FAIL rnd_%0d_bus: got %h/%b/%b expected %h/%b/1", i, obs_addr, obs_we, obs_stable, a & 32'hFFFFFFFC, st); else passed++;
                total++; if (obs_be !== ref_be(st, sz, a)) $display("[TB] FAIL rnd_%0d_be: got %b expected %b", i, obs_be, ref_be(st, sz, a)); else passed++;
                if (st) begin
                    total++; if (obs_wdata !== ref_wdata(sz, wd)) $display("[TB] FAIL rnd_%0d_wdata: got %h expected %h", i, obs_wdata, ref_wdata(sz, wd)); else passed++;
                end
            end else begin
                total++; if (obs_fault !== 1 || obs_req_idle !== 1'b0 || obs_stall !== 0) $display("[TB] FAIL rnd_%0d_illegal: got %0d/%b/%0d expected 1/0/0", i, obs_fault, obs_req_idle, obs_stall); else passed++;
            end
            total++; if (obs_rdata_after !== model_rdata) $display("[TB] FAIL rnd_%0d_rdata: got %h expected %h", i, obs_rdata_after, model_rdata); else passed++;
        end
    endtask

    // Reset in the middle of a load abandons it; a late ack is ignored.
    task automatic test_reset_mid_busy();
        ld_en = 1'b1; st_en = 1'b0; size = 3'd2; addr = 32'h30; mem_rdata = 32'hCAFEF00D; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (mem_req !== 1'b1) $display("[TB] FAIL rstb_busy_req: got %b expected 1", mem_req); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({stall, fault, mem_req, mem_we, mem_be} !== 8'h0) $display("[TB] FAIL rstb_ctrl: got %h expected 0", {stall, fault, mem_req, mem_we, mem_be}); else passed++;
        total++; if ({mem_addr, mem_wdata, rdata} !== 96'h0) $display("[TB] FAIL rstb_data: got %h expected 0", {mem_addr, mem_wdata, rdata}); else passed++;
        model_rdata = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0; ld_en = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(negedge clk);
        total++; if (mem_req !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL rstb_idle: got %b%b expected 00", mem_req, stall); else passed++;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        total++; if (rdata !== 32'h0) $display("[TB] FAIL rstb_late_ack: got %h expected 00000000", rdata); else passed++;
        @(posedge clk); #1;
        run_access(1'b1, 1'b0, 3'd2, 32'h30, 32'h0, 32'hCAFEF00D, 0, 1'b0, 1'b0);
        model_rdata = 32'hCAFEF00D;
        total++; if (obs_stall !== 2 || obs_rdata !== 32'hCAFEF00D) $display("[TB] FAIL rstb_recover: got %0d/%h expected 2/cafef00d", obs_stall, obs_rdata); else passed++;
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_sh();
        test_fault();
        test_delayed_store();
        test_back_to_back();
        test_random();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop so a wedged run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: AW, 32, address width.
REQ-002 SHALL have port: clk  in  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: ld_en  in  1  load instruction in execute; held by datapath while stall=1.
REQ-005 SHALL have port: st_en  in  1  store instruction in execute; held while stall=1.
REQ-006 SHALL have port: size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-007 SHALL have port: addr  in  AW  effective address (ALU result).
REQ-008 SHALL have port: wdata  in  32  store data (rs2).
REQ-009 SHALL have port: rdata  out  32  aligned, extended load result to writeback mux.
REQ-010 SHALL have port: stall  out  1  freeze PC/regfile write while access is pending.
REQ-011 SHALL have port: fault  out  1  one-cycle pulse, misaligned or illegal size.
REQ-012 SHALL have ports: mem_req/mem_we out 1; mem_addr out AW; mem_be out 4; mem_wdata out 32.
REQ-013 SHALL have ports: mem_rdata in 32; mem_ack in 1.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-015 IDLE: on ld_en|st_en with legal, aligned access, SHALL assert stall combinationally, register the request, go BUSY.
REQ-016 Simultaneous ld_en and st_en SHALL be treated as a store.
REQ-017 Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) or illegal size (011,110,111; BU/HU on store) SHALL pulse fault for one cycle, issue no bus request, keep stall=0, leave rdata unchanged, stay IDLE.
REQ-018 BUSY: mem_req=1, mem_we=store, mem_addr={addr[AW-1:2],2'b00}, mem_be, mem_wdata SHALL hold stable until mem_ack; stall=1.
REQ-019 Store byte enables SHALL be B: 4'b0001<<addr[1:0]; H: 4'b0011<<addr[1:0]; W: 4'b1111; load mem_be SHALL be 4'b1111.
REQ-020 Store data SHALL be replicated: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
REQ-021 On mem_ack in BUSY, SHALL register load result into rdata (B/H sign-extend, BU/HU zero-extend, lane selected by addr[1:0]), drop mem_req next cycle, go DONE.
REQ-022 DONE: stall=0 for exactly one cycle, rdata valid; enables SHALL NOT be resampled in DONE; next access sampled back in IDLE.
REQ-023 Minimum latency with ack in first BUSY cycle: 3 cycles, 2 stalled; each extra wait cycle adds one.
REQ-024 mem_ack outside BUSY SHALL be ignored.
REQ-025 Stores SHALL leave rdata unchanged.

Reset
REQ-026 rst SHALL force IDLE and rdata, stall, fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata to 0 immediately.
REQ-027 rst during BUSY SHALL abandon the transaction; a later mem_ack SHALL be ignored.

Structure
REQ-028 Shared package SHALL hold size encodings and FSM state enum.
REQ-029 Combinational lane logic (byte enables, store replication, load extraction/extension) SHALL be sub-module load_align.

Verification
REQ-030 LW addr=0x10, mem_rdata=0xDEADBEEF, ack first BUSY cycle -> mem_be=1111, stall 2 cycles, rdata=0xDEADBEEF in DONE.
REQ-031 LB addr=0x13, mem_rdata=0x80FF0000 -> rdata=0xFFFFFF80; LBU same -> rdata=0x00000080.
REQ-032 SH addr=0x22, wdata=0x12345678 -> mem_we=1, mem_be=1100, mem_wdata=0x56785678, mem_addr=0x20.
REQ-033 LW addr=0x11 -> fault pulse 1 cycle, mem_req never 1, stall=0, rdata unchanged.
REQ-034 SW, ack delayed 4 cycles -> mem_* stable throughout, stall 5 cycles, mem_req low cycle after ack.
REQ-035 rst asserted mid-BUSY, late ack after rst release -> IDLE, all outputs 0, no rdata update.
